mtimer: RTL and testbench

Machine-timer block for the QianTang core. It consumes the slow toggle produced by the real-time divider and counts one tick of the 64-bit `mtime` register per toggle edge. It compares `mtime` against `mtimecmp` and drives the machine timer interrupt. Both registers are exposed to the core through a simple 32-bit register port.

---
 rtl/mtimer.sv | 133 +++++++++++++
 tb/tb_mtimer.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mtimer.sv
// Machine timer: 64-bit mtime counted from real-time toggles,
// mtimecmp compare and a 32-bit register port.
module mtimer #(
  parameter int          SYNC_STAGES  = 2,
  parameter logic [63:0] MTIMECMP_RST = 64'hFFFF_FFFF_FFFF_FFFF
) (
  input  logic        clk_sys_i,
  input  logic        rst_sys_n_i,
  input  logic        real_time_i,
  input  logic        req_valid_i,
  input  logic        req_we_i,
  input  logic [3:0]  req_addr_i,
  input  logic [31:0] req_wdata_i,
  output logic        rsp_valid_o,
  output logic [31:0] rsp_rdata_o,
  output logic        rsp_err_o,
  output logic        mtip_o
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   delay_q, delay_d;
  logic                   armed_q;
  logic                   tick;

  logic [63:0] mtime_q, mtime_d;
  logic [63:0] mtimecmp_q, mtimecmp_d;
  logic [31:0] hi_shadow_q, hi_shadow_d;

  logic        rsp_valid_q;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  logic        rsp_err_q, rsp_err_d;
  logic        mtip_q;

  logic        misal;
  logic        wr;
  logic        rd;
  logic [1:0]  sel;

  assign misal = (req_addr_i[1:0] != 2'b00);
  assign wr    = req_valid_i & req_we_i & ~misal;
  assign rd    = req_valid_i & ~req_we_i & ~misal;
  assign sel   = req_addr_i[3:2];

  // Sync chain next state; the unarmed cycle seeds the whole chain with
  // the current level so a level present at reset release is no tick.
  always_comb begin
    sync_d  = {sync_q[SYNC_STAGES-2:0], real_time_i};
    delay_d = sync_q[SYNC_STAGES-1];
    if (!armed_q) begin
      sync_d  = {SYNC_STAGES{real_time_i}};
      delay_d = real_time_i;
    end
  end

  assign tick = armed_q & (sync_q[SYNC_STAGES-1] ^ delay_q);

  // Tick path flops: synchronizer, edge-detect delay and arm flag.
  always_ff @(posedge clk_sys_i) begin
    if (!rst_sys_n_i) begin
      sync_q  <= '0;
      delay_q <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      delay_q <= delay_d;
      armed_q <= 1'b1;
    end
  end

  // Counter/compare/shadow next state; an mtime write drops a same-cycle tick.
  always_comb begin
    mtime_d     = mtime_q;
    mtimecmp_d  = mtimecmp_q;
    hi_shadow_d = hi_shadow_q;
    if (wr && sel == 2'd0) begin
      mtime_d = {mtime_q[63:32], req_wdata_i};
    end else if (wr && sel == 2'd1) begin
      mtime_d = {req_wdata_i, mtime_q[31:0]};
    end else if (tick) begin
      mtime_d = mtime_q + 64'd1;
    end
    if (wr && sel == 2'd2) begin
      mtimecmp_d = {mtimecmp_q[63:32], req_wdata_i};
    end else if (wr && sel == 2'd3) begin
      mtimecmp_d = {req_wdata_i, mtimecmp_q[31:0]};
    end
    if (rd && sel == 2'd0) begin
      hi_shadow_d = mtime_q[63:32];
    end
  end

  // Response data next state: reads only, zero on writes and errors.
  always_comb begin
    rsp_rdata_d = 32'h0;
    rsp_err_d   = req_valid_i & misal;
    if (rd) begin
      unique case (sel)
        2'd0: rsp_rdata_d = mtime_q[31:0];
        2'd1: rsp_rdata_d = hi_shadow_q;
        2'd2: rsp_rdata_d = mtimecmp_q[31:0];
        2'd3: rsp_rdata_d = mtimecmp_q[63:32];
        default: rsp_rdata_d = 32'h0;
      endcase
    end
  end

  // Architectural registers, response and interrupt flops.
  always_ff @(posedge clk_sys_i) begin
    if (!rst_sys_n_i) begin
      mtime_q     <= 64'h0;
      mtimecmp_q  <= MTIMECMP_RST;
      hi_shadow_q <= 32'h0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'h0;
      rsp_err_q   <= 1'b0;
      mtip_q      <= 1'b0;
    end else begin
      mtime_q     <= mtime_d;
      mtimecmp_q  <= mtimecmp_d;
      hi_shadow_q <= hi_shadow_d;
      rsp_valid_q <= req_valid_i;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      mtip_q      <= (mtime_q >= mtimecmp_q);
    end
  end

  assign rsp_valid_o = rsp_valid_q;
  assign rsp_rdata_o = rsp_rdata_q;
  assign rsp_err_o   = rsp_err_q;
  assign mtip_o      = mtip_q;

endmodule

// File: tb/tb_mtimer.sv
// Directed bench for mtimer: register table plus
// hand-built tick, carry, interrupt and collision sequences.
module tb_mtimer;

  logic        clk;
  logic        rst_n;
  logic        rt;
  logic        req_valid;
  logic        req_we;
  logic [3:0]  req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        mtip;

  int n_pass;
  int n_total;

  mtimer dut (
    .clk_sys_i   (clk),
    .rst_sys_n_i (rst_n),
    .real_time_i (rt),
    .req_valid_i (req_valid),
    .req_we_i    (req_we),
    .req_addr_i  (req_addr),
    .req_wdata_i (req_wdata),
    .rsp_valid_o (rsp_valid),
    .rsp_rdata_o (rsp_rdata),
    .rsp_err_o   (rsp_err),
    .mtip_o      (mtip)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [3:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        err;
  } vec_t;

  vec_t tbl[16];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic access(input logic we, input logic [3:0] addr,
                        input logic [31:0] wd, input logic [31:0] exp_rd,
                        input logic exp_err, input string nm);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wd;
    step();
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_wdata = 32'h0;
    chk({nm, " valid"}, {63'h0, rsp_valid}, 64'h1);
    chk({nm, " rdata"}, {32'h0, rsp_rdata}, {32'h0, exp_rd});
    chk({nm, " err"}, {63'h0, rsp_err}, {63'h0, exp_err});
  endtask

  task automatic toggle();
    rt = ~rt;
    repeat (8) step();
  endtask

  // Toggle and check mtip stays low for 3 edges then rises on the 4th.
  task automatic toggle_rise(input string nm);
    rt = ~rt;
    for (int e = 1; e <= 3; e++) begin
      step();
      chk({nm, " mtip pre"}, {63'h0, mtip}, 64'h0);
    end
    step();
    chk({nm, " mtip edge4"}, {63'h0, mtip}, 64'h1);
    repeat (4) step();
  endtask

  initial begin
    n_pass    = 0;
    n_total   = 0;
    rst_n     = 1'b0;
    rt        = 1'b1;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_addr  = 4'h0;
    req_wdata = 32'h0;

    tbl[0]  = '{1'b0, 4'h0, 32'h0,         32'h0,         1'b0};
    tbl[1]  = '{1'b0, 4'h4, 32'h0,         32'h0,         1'b0};
    tbl[2]  = '{1'b0, 4'hC, 32'h0,         32'hFFFF_FFFF, 1'b0};
    tbl[3]  = '{1'b0, 4'h8, 32'h0,         32'hFFFF_FFFF, 1'b0};
    tbl[4]  = '{1'b1, 4'h8, 32'h1234_5678, 32'h0,         1'b0};
    tbl[5]  = '{1'b0, 4'h8, 32'h0,         32'h1234_5678, 1'b0};
    tbl[6]  = '{1'b1, 4'h0, 32'hAAAA_5555, 32'h0,         1'b0};
    tbl[7]  = '{1'b1, 4'h4, 32'h0000_0003, 32'h0,         1'b0};
    tbl[8]  = '{1'b0, 4'h0, 32'h0,         32'hAAAA_5555, 1'b0};
    tbl[9]  = '{1'b1, 4'h4, 32'h0000_0007, 32'h0,         1'b0};
    tbl[10] = '{1'b0, 4'h4, 32'h0,         32'h0000_0003, 1'b0};
    tbl[11] = '{1'b0, 4'h2, 32'h0,         32'h0,         1'b1};
    tbl[12] = '{1'b1, 4'h1, 32'hDEAD_BEEF, 32'h0,         1'b1};
    tbl[13] = '{1'b0, 4'h0, 32'h0,         32'hAAAA_5555, 1'b0};
    tbl[14] = '{1'b0, 4'hE, 32'h0,         32'h0,         1'b1};
    tbl[15] = '{1'b0, 4'h4, 32'h0,         32'h0000_0007, 1'b0};

    // Reset with real_time high
    repeat (3) step();
    chk("rst rsp_valid", {63'h0, rsp_valid}, 64'h0);
    chk("rst mtip", {63'h0, mtip}, 64'h0);
    rst_n = 1'b1;
    for (int c = 0; c < 10; c++) begin
      step();
      chk("idle outs", {30'h0, rsp_valid, rsp_err, rsp_rdata, mtip},
          64'h0);
    end

    // Back-to-back register table
    for (int i = 0; i < 16; i++) begin
      req_valid = 1'b1;
      req_we    = tbl[i].we;
      req_addr  = tbl[i].addr;
      req_wdata = tbl[i].wdata;
      step();
      chk($sformatf("tbl%0d valid", i), {63'h0, rsp_valid}, 64'h1);
      chk($sformatf("tbl%0d rdata", i), {32'h0, rsp_rdata},
          {32'h0, tbl[i].rdata});
      chk($sformatf("tbl%0d err", i), {63'h0, rsp_err},
          {63'h0, tbl[i].err});
    end
    req_valid = 1'b0;
    req_we    = 1'b0;
    step();
    chk("tbl idle valid", {63'h0, rsp_valid}, 64'h0);

    // Five toggles, first one timed through mtip with mtimecmp=1
    access(1'b1, 4'h0, 32'h0, 32'h0, 1'b0, "clr lo");
    access(1'b1, 4'h4, 32'h0, 32'h0, 1'b0, "clr hi");
    access(1'b1, 4'h8, 32'h1, 32'h0, 1'b0, "cmp lo1");
    access(1'b1, 4'hC, 32'h0, 32'h0, 1'b0, "cmp hi0");
    step();
    step();
    chk("cmp1 mtip low", {63'h0, mtip}, 64'h0);
    toggle_rise("tick1");
    repeat (4) toggle();
    access(1'b0, 4'h0, 32'h0, 32'd5, 1'b0, "five lo");
    access(1'b0, 4'h4, 32'h0, 32'd0, 1'b0, "five hi");

    // Carry across the 32-bit boundary
    access(1'b1, 4'h0, 32'hFFFF_FFFE, 32'h0, 1'b0, "wr FE lo");
    access(1'b1, 4'h4, 32'h0, 32'h0, 1'b0, "wr FE hi");
    repeat (3) toggle();
    access(1'b0, 4'h0, 32'h0, 32'h1, 1'b0, "carry lo");
    toggle();
    access(1'b0, 4'h4, 32'h0, 32'h1, 1'b0, "shadow hi");
    access(1'b0, 4'h0, 32'h0, 32'h2, 1'b0, "after lo");

    // Carry between lo read and hi read
    access(1'b1, 4'h0, 32'hFFFF_FFFF, 32'h0, 1'b0, "wr FF lo");
    access(1'b1, 4'h4, 32'h0, 32'h0, 1'b0, "wr FF hi");
    access(1'b0, 4'h0, 32'h0, 32'hFFFF_FFFF, 1'b0, "pair lo");
    toggle();
    access(1'b0, 4'h4, 32'h0, 32'h0, 1'b0, "pair hi");
    access(1'b0, 4'h0, 32'h0, 32'h0, 1'b0, "fresh lo");
    access(1'b0, 4'h4, 32'h0, 32'h1, 1'b0, "fresh hi");

    // mtimecmp=4 rise, then raise cmp hi
    access(1'b1, 4'h0, 32'h0, 32'h0, 1'b0, "m0 lo");
    access(1'b1, 4'h4, 32'h0, 32'h0, 1'b0, "m0 hi");
    access(1'b1, 4'h8, 32'h4, 32'h0, 1'b0, "cmp4 lo");
    repeat (3) toggle();
    chk("three mtip", {63'h0, mtip}, 64'h0);
    toggle_rise("tick4");
    access(1'b1, 4'hC, 32'h1, 32'h0, 1'b0, "cmp hi1");
    chk("cmp hi1 edge1", {63'h0, mtip}, 64'h1);
    step();
    chk("cmp hi1 edge2", {63'h0, mtip}, 64'h0);

    // Wrap at all ones
    access(1'b1, 4'h8, 32'hFFFF_FFFF, 32'h0, 1'b0, "cmpF lo");
    access(1'b1, 4'hC, 32'hFFFF_FFFF, 32'h0, 1'b0, "cmpF hi");
    access(1'b1, 4'h0, 32'hFFFF_FFFF, 32'h0, 1'b0, "mF lo");
    access(1'b1, 4'h4, 32'hFFFF_FFFF, 32'h0, 1'b0, "mF hi");
    step();
    chk("allF mtip", {63'h0, mtip}, 64'h1);
    toggle();
    chk("wrap mtip", {63'h0, mtip}, 64'h0);
    access(1'b0, 4'h0, 32'h0, 32'h0, 1'b0, "wrap lo");
    access(1'b0, 4'h4, 32'h0, 32'h0, 1'b0, "wrap hi");

    // Tick colliding with mtime lo write: write wins
    rt = ~rt;
    step();
    step();
    access(1'b1, 4'h0, 32'h100, 32'h0, 1'b0, "coll wr");
    repeat (8) step();
    access(1'b0, 4'h0, 32'h0, 32'h100, 1'b0, "coll lo");

    // Tick colliding with mtimecmp write: tick kept
    rt = ~rt;
    step();
    step();
    access(1'b1, 4'h8, 32'h50, 32'h0, 1'b0, "cmpcoll wr");
    repeat (8) step();
    access(1'b0, 4'h0, 32'h0, 32'h101, 1'b0, "cmpcoll lo");
    access(1'b0, 4'h8, 32'h0, 32'h50, 1'b0, "cmpcoll cmp");

    // Misaligned access leaves state alone
    access(1'b1, 4'h2, 32'h0BAD_0BAD, 32'h0, 1'b1, "mis wr");
    access(1'b0, 4'h2, 32'h0, 32'h0, 1'b1, "mis rd");
    access(1'b0, 4'h0, 32'h0, 32'h101, 1'b0, "mis lo");

    // Reset during a pending read drops the response
    req_valid = 1'b1;
    req_addr  = 4'h8;
    rst_n     = 1'b0;
    step();
    req_valid = 1'b0;
    chk("rst drop valid", {63'h0, rsp_valid}, 64'h0);
    chk("rst drop rdata", {32'h0, rsp_rdata}, 64'h0);
    rst_n = 1'b1;
    step();
    step();
    access(1'b0, 4'hC, 32'h0, 32'hFFFF_FFFF, 1'b0, "post rst cmp");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
